// File: rtl/opl3_slot_scheduler.sv
// OPL3 frame sequencer: sample-rate divider, 36 operator slot strobes per frame, and a host write FIFO.
// Writes are released only outside the slot window; ready drops when the FIFO is full and late writes are dropped (sticky flag).
package opl3_pkg;
  localparam int CLK_DIV_COUNT = 494;
  localparam int OP_NUM_WIDTH  = 5;

  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;
endpackage

module opl3_slot_scheduler #(
  parameter int CLK_DIV_COUNT = opl3_pkg::CLK_DIV_COUNT,
  parameter int SLOT_SPACING  = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  opl3_pkg::opl3_reg_wr_t               reg_wr_in,
  output logic                                 reg_wr_in_ready,
  output opl3_pkg::opl3_reg_wr_t               reg_wr_out,
  output logic                                 sample_clk_en,
  output logic                                 slot_valid,
  output logic                                 slot_bank,
  output logic [opl3_pkg::OP_NUM_WIDTH-1:0]    slot_op,
  output logic                                 frame_busy,
  output logic                                 wr_dropped
);
  localparam int CW = $clog2(CLK_DIV_COUNT);
  localparam int SW = $clog2(SLOT_SPACING) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam int OW = opl3_pkg::OP_NUM_WIDTH;

  typedef enum logic [1:0] {ST_WAIT, ST_SLOTS, ST_WRITES} state_t;
  typedef logic [16:0] entry_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          spc_q, spc_d;
  logic [5:0]             idx_q, idx_d;
  logic                   sample_q, sample_d;
  logic                   slot_valid_q, slot_valid_d;
  logic                   slot_bank_q, slot_bank_d;
  logic [OW-1:0]          slot_op_q, slot_op_d;
  logic                   wr_dropped_q, wr_dropped_d;
  entry_t                 mem_q [FIFO_DEPTH];
  entry_t                 mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]          count_q, count_d;
  opl3_pkg::opl3_reg_wr_t reg_wr_out_q, reg_wr_out_d;
  logic                   wrap, issue, push, pop;
  entry_t                 head;

  // spc/idx pace the slots; a slot strobe is registered, so it shows one cycle after issue
  always_comb begin
    wrap    = (cnt_q == CW'(CLK_DIV_COUNT - 1));
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    issue   = (state_q == ST_SLOTS) && (spc_q == '0) && (idx_q < 6'd36);
    state_d = state_q;
    spc_d   = '0;
    idx_d   = '0;
    if (wrap) begin
      state_d = ST_SLOTS;
    end else if (state_q == ST_SLOTS) begin
      if (idx_q == 6'd36) state_d = ST_WRITES;
      spc_d = (spc_q == SW'(SLOT_SPACING - 1)) ? '0 : spc_q + 1'b1;
      idx_d = issue ? idx_q + 6'd1 : idx_q;
    end
    sample_d     = wrap;
    slot_valid_d = issue;
    slot_bank_d  = slot_bank_q;
    slot_op_d    = slot_op_q;
    if (issue) begin
      slot_bank_d = (idx_q >= 6'd18);
      slot_op_d   = (idx_q >= 6'd18) ? OW'(idx_q - 6'd18) : OW'(idx_q);
    end
  end

  // An empty FIFO bypasses the incoming write straight into the output register
  always_comb begin
    reg_wr_in_ready = (count_q < NW'(FIFO_DEPTH));
    push            = reg_wr_in.valid && reg_wr_in_ready;
    pop             = (state_d != ST_SLOTS) && ((count_q != '0) || push);
    head            = (count_q == '0) ? {reg_wr_in.bank_num, reg_wr_in.address, reg_wr_in.data}
                                      : mem_q[rd_ptr_q];
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    reg_wr_out_d = '0;
    wr_dropped_d = wr_dropped_q | (reg_wr_in.valid && !reg_wr_in_ready);
    if (push) begin
      mem_d[wr_ptr_q] = {reg_wr_in.bank_num, reg_wr_in.address, reg_wr_in.data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      reg_wr_out_d = {1'b1, head};
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_WAIT;
      cnt_q        <= '0;
      spc_q        <= '0;
      idx_q        <= '0;
      sample_q     <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_bank_q  <= 1'b0;
      slot_op_q    <= '0;
      wr_dropped_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      reg_wr_out_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      spc_q        <= spc_d;
      idx_q        <= idx_d;
      sample_q     <= sample_d;
      slot_valid_q <= slot_valid_d;
      slot_bank_q  <= slot_bank_d;
      slot_op_q    <= slot_op_d;
      wr_dropped_q <= wr_dropped_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      reg_wr_out_q <= reg_wr_out_d;
      mem_q        <= mem_d;
    end
  end

  assign sample_clk_en = sample_q;
  assign slot_valid    = slot_valid_q;
  assign slot_bank     = slot_bank_q;
  assign slot_op       = slot_op_q;
  assign frame_busy    = (state_q == ST_SLOTS);
  assign wr_dropped    = wr_dropped_q;
  assign reg_wr_out    = reg_wr_out_q;
endmodule

// File: tb/tb_opl3_slot_scheduler.sv
// Directed bench for opl3_slot_scheduler with default parameters (494-clock frame, spacing 8, depth 4).
module tb_opl3_slot_scheduler;
  import opl3_pkg::*;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  opl3_reg_wr_t            reg_wr_in = '0;
  opl3_reg_wr_t            reg_wr_out;
  logic                    reg_wr_in_ready, sample_clk_en, slot_valid, slot_bank, frame_busy, wr_dropped;
  logic [OP_NUM_WIDTH-1:0] slot_op;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  always #5 clk = ~clk;

  opl3_slot_scheduler dut (
    .clk(clk), .resetn(resetn),
    .reg_wr_in(reg_wr_in), .reg_wr_in_ready(reg_wr_in_ready),
    .reg_wr_out(reg_wr_out), .sample_clk_en(sample_clk_en),
    .slot_valid(slot_valid), .slot_bank(slot_bank), .slot_op(slot_op),
    .frame_busy(frame_busy), .wr_dropped(wr_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int c);
    while ((n % 494) != c) tick();
  endtask

  function automatic opl3_reg_wr_t wr(input logic b, input logic [7:0] a, input logic [7:0] d);
    opl3_reg_wr_t w;
    w.valid = 1'b1; w.bank_num = b; w.address = a; w.data = d;
    return w;
  endfunction

  // Advance to cnt 282 while counting any write released during the slot window
  task automatic run_to_window(input string tag);
    int leaks = 0;
    while ((n % 494) != 282) begin
      tick();
      if ((n % 494) != 282 && reg_wr_out.valid) leaks++;
    end
    chk(tag, leaks, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sample"}, sample_clk_en, 0);
    chk({tag, "_slot_valid"}, slot_valid, 0);
    chk({tag, "_slot_bank"}, slot_bank, 0);
    chk({tag, "_slot_op"}, slot_op, 0);
    chk({tag, "_busy"}, frame_busy, 0);
    chk({tag, "_out"}, reg_wr_out, 0);
    chk({tag, "_dropped"}, wr_dropped, 0);
    chk({tag, "_ready"}, reg_wr_in_ready, 1);
  endtask

  initial begin
    int pulses, p1, p2, early_bad, k, slots1, busy_bad, stale, first_pulse;
    logic [7:0] waddr [3];
    waddr[0] = 8'h01; waddr[1] = 8'h04; waddr[2] = 8'h05;

    // Reset and idle: pulses at 494/988, full slot sequence in the first live frame
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    pulses = 0; p1 = -1; p2 = -1; early_bad = 0; k = 0; slots1 = 0; busy_bad = 0;
    repeat (1000) begin
      tick();
      if (sample_clk_en) begin
        pulses++;
        if (pulses == 1) p1 = n;
        else if (pulses == 2) p2 = n;
      end
      if (n < 494 && (sample_clk_en || slot_valid || slot_bank || slot_op != 0 || frame_busy ||
                      reg_wr_out != 0 || wr_dropped || !reg_wr_in_ready)) early_bad++;
      if (n >= 494 && n < 988) begin
        if (slot_valid) begin
          slots1++;
          if (k < 36) begin
            chk($sformatf("slot%0d_cnt", k), n - 494, 1 + 8 * k);
            chk($sformatf("slot%0d_bank", k), slot_bank, k / 18);
            chk($sformatf("slot%0d_op", k), slot_op, k % 18);
          end
          k++;
        end
        if (frame_busy !== ((n - 494) <= 281)) busy_bad++;
      end
    end
    chk("pulse_count", pulses, 2);
    chk("pulse1_cycle", p1, 494);
    chk("pulse2_cycle", p2, 988);
    chk("idle_before_first_pulse", early_bad, 0);
    chk("slots_per_frame", slots1, 36);
    chk("frame_busy_window", busy_bad, 0);

    // Single write in SLOTS is held until the window opens
    run_to(50);
    reg_wr_in = wr(1'b1, 8'hB0, 8'h2A);
    tick();
    reg_wr_in = '0;
    chk("single_ready", reg_wr_in_ready, 1);
    run_to_window("single_leak");
    chk("single_out", reg_wr_out, wr(1'b1, 8'hB0, 8'h2A));
    tick();
    chk("single_out_end", reg_wr_out.valid, 0);

    // Six back-to-back writes in SLOTS: four kept, two dropped
    run_to(100);
    for (int i = 0; i < 6; i++) begin
      reg_wr_in = wr(i[0], 8'h10 + 8'(i), 8'h60 + 8'(i));
      tick();
      chk($sformatf("burst_ready%0d", i), reg_wr_in_ready, (i < 3) ? 1 : 0);
      chk($sformatf("burst_dropped%0d", i), wr_dropped, (i >= 4) ? 1 : 0);
    end
    reg_wr_in = '0;
    run_to_window("burst_leak");
    chk("burst_out0", reg_wr_out, wr(1'b0, 8'h10, 8'h60));
    chk("burst_ready_after_pop", reg_wr_in_ready, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("burst_out%0d", i), reg_wr_out, wr(i[0], 8'h10 + 8'(i), 8'h60 + 8'(i)));
    end
    tick();
    chk("burst_out_end", reg_wr_out.valid, 0);
    chk("dropped_sticky", wr_dropped, 1);

    // Writes in WAIT pass through with one cycle latency
    resetn = 1'b0;
    #2;
    chk("dropped_cleared", wr_dropped, 0);
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      reg_wr_in = wr(1'b0, waddr[i], waddr[i] + 8'h30);
      tick();
      chk($sformatf("wait_out%0d", i), reg_wr_out, wr(1'b0, waddr[i], waddr[i] + 8'h30));
    end
    reg_wr_in = '0;
    tick();
    chk("wait_out_end", reg_wr_out.valid, 0);

    // Mid-frame reset with three queued writes
    run_to(0);
    chk("frame_after_reset", sample_clk_en, 1);
    run_to(97);
    for (int i = 0; i < 3; i++) begin
      reg_wr_in = wr(1'b1, 8'h40 + 8'(i), 8'h70 + 8'(i));
      tick();
    end
    reg_wr_in = '0;
    chk("pre_abort_busy", frame_busy, 1);
    chk("pre_abort_op", slot_op, 12);
    #1;
    resetn = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    stale = 0;
    first_pulse = -1;
    repeat (600) begin
      tick();
      if (reg_wr_out.valid) stale++;
      if (sample_clk_en && first_pulse < 0) first_pulse = n;
    end
    chk("abort_no_stale", stale, 0);
    chk("abort_first_pulse", first_pulse, 494);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
